// File: rtl/gcd_datapath_pkg.sv
// Shared definitions for the GCD datapath and the control FSM that drives it.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;
    localparam int GCD_CNT_W = 8;

    // Control FSM states; the datapath decodes its flag inputs into this type.
    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FINISH  = 2'd2
    } gcd_state_e;

    // True when exactly one of the three state flags is asserted.
    function automatic logic flags_onehot(input logic init_f, input logic comp_f, input logic fin_f);
        return ({init_f, comp_f, fin_f} == 3'b100) ||
               ({init_f, comp_f, fin_f} == 3'b010) ||
               ({init_f, comp_f, fin_f} == 3'b001);
    endfunction

endpackage

// File: rtl/gcd_datapath_sub_step.sv
// One Euclid subtraction step: compare the two operands and form the
// larger-minus-smaller difference, so the result never wraps.
module gcd_sub_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             eq,
    output logic [WIDTH-1:0] difference
);

    // Compare and subtract the smaller operand from the larger one.
    always_comb begin
        a_gt_b     = (a > b);
        eq         = (a == b);
        difference = a_gt_b ? (a - b) : (b - a);
    end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers, saturating step counter, result register
// and sticky protocol-error flag, steered by one-hot state flags from an
// external control FSM.
//
// Flag/enable protocol: on every rising edge exactly one of flag_init_i,
// flag_compute_i, flag_finish_i must be high; the datapath advances only on
// edges where gcd_enable_i is high, and the FSM is expected to follow
// compute_enable_o / compare_zero_o on those same edges. Any other flag
// combination latches flag_error_o, forces both requests low and freezes the
// datapath for that edge.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = GCD_CNT_W
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             gcd_enable_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flag_init_i,
    input  logic             flag_compute_i,
    input  logic             flag_finish_i,
    output logic             compute_enable_o,
    output logic             compare_zero_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] iter_count_o,
    output logic             flag_error_o
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             a_gt_b;
    logic             regs_eq;
    logic [WIDTH-1:0] difference;
    logic             flags_ok;
    logic             operand_zero;
    gcd_state_e       phase;

    gcd_sub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a          (a_reg),
        .b          (b_reg),
        .a_gt_b     (a_gt_b),
        .eq         (regs_eq),
        .difference (difference)
    );

    // Decode the flag inputs into a phase and flag illegal combinations.
    always_comb begin
        flags_ok     = flags_onehot(flag_init_i, flag_compute_i, flag_finish_i);
        operand_zero = (a_i == '0) || (b_i == '0);
        phase        = S_INIT;
        if (flag_compute_i) begin
            phase = S_COMPUTE;
        end else if (flag_finish_i) begin
            phase = S_FINISH;
        end
    end

    // Requests to the FSM; both stay low in finish or on a flag violation.
    always_comb begin
        compute_enable_o = 1'b0;
        compare_zero_o   = 1'b0;
        if (flags_ok) begin
            case (phase)
                S_INIT: begin
                    compute_enable_o = !operand_zero;
                    compare_zero_o   = operand_zero;
                end
                S_COMPUTE: begin
                    compare_zero_o = regs_eq;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers: load in init, step in compute, mark valid in finish.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            a_reg          <= '0;
            b_reg          <= '0;
            result_o       <= '0;
            iter_count_o   <= '0;
            result_valid_o <= 1'b0;
            flag_error_o   <= 1'b0;
        end else if (!flags_ok) begin
            flag_error_o <= 1'b1;
        end else if (gcd_enable_i) begin
            case (phase)
                S_INIT: begin
                    a_reg          <= a_i;
                    b_reg          <= b_i;
                    iter_count_o   <= '0;
                    result_valid_o <= 1'b0;
                    // A zero operand finishes immediately: gcd(0,x)=x.
                    if (operand_zero) begin
                        result_o <= a_i | b_i;
                    end
                end
                S_COMPUTE: begin
                    if (regs_eq) begin
                        result_o <= a_reg;
                    end else begin
                        if (a_gt_b) begin
                            a_reg <= difference;
                        end else begin
                            b_reg <= difference;
                        end
                        if (iter_count_o != {CNT_W{1'b1}}) begin
                            iter_count_o <= iter_count_o + CNT_W'(1);
                        end
                    end
                end
                S_FINISH: begin
                    result_valid_o <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: a small control FSM drives the flags, directed
// vectors push expected {result, count, error} words into queues, and
// monitors compare them whenever result_valid_o rises.
module tb_gcd_datapath;
    import gcd_pkg::*;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           nreset;
    logic           gcd_enable;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           force_bad;
    gcd_state_e     state;
    logic           flag_init;
    logic           flag_compute;
    logic           flag_finish;

    logic           ce;
    logic           cz;
    logic [W-1:0]   res;
    logic           res_valid;
    logic [7:0]     iter;
    logic           err;

    logic           c4_ce;
    logic           c4_cz;
    logic [W-1:0]   c4_res;
    logic           c4_valid;
    logic [3:0]     c4_iter;
    logic           c4_err;

    int             n_vec  = 0;
    int             n_miss = 0;
    logic [24:0]    exp_q[$];
    logic [24:0]    exp4_q[$];

    gcd_datapath #(.WIDTH(W), .CNT_W(8)) dut (
        .clk_i            (clk),
        .nreset_i         (nreset),
        .gcd_enable_i     (gcd_enable),
        .a_i              (a_in),
        .b_i              (b_in),
        .flag_init_i      (flag_init),
        .flag_compute_i   (flag_compute),
        .flag_finish_i    (flag_finish),
        .compute_enable_o (ce),
        .compare_zero_o   (cz),
        .result_o         (res),
        .result_valid_o   (res_valid),
        .iter_count_o     (iter),
        .flag_error_o     (err)
    );

    gcd_datapath #(.WIDTH(W), .CNT_W(4)) dut_c4 (
        .clk_i            (clk),
        .nreset_i         (nreset),
        .gcd_enable_i     (gcd_enable),
        .a_i              (a_in),
        .b_i              (b_in),
        .flag_init_i      (flag_init),
        .flag_compute_i   (flag_compute),
        .flag_finish_i    (flag_finish),
        .compute_enable_o (c4_ce),
        .compare_zero_o   (c4_cz),
        .result_o         (c4_res),
        .result_valid_o   (c4_valid),
        .iter_count_o     (c4_iter),
        .flag_error_o     (c4_err)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Control FSM driving the state flags
    assign flag_init    = (state == S_INIT);
    assign flag_compute = (state == S_COMPUTE) || force_bad;
    assign flag_finish  = (state == S_FINISH);

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_INIT;
        end else if (gcd_enable && !force_bad) begin
            case (state)
                S_INIT: begin
                    if (cz) state <= S_FINISH;
                    else if (ce) state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (cz) state <= S_FINISH;
                end
                default: begin
                end
            endcase
        end
    end

    // Helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pack(input logic [15:0] r, input int it, input logic e, input int maxc);
        int sat;
        sat = (it > maxc) ? maxc : it;
        return {r, 8'(sat), e};
    endfunction

    // Scoreboard monitors: pop on each rising edge of result_valid_o
    initial begin
        logic        prev;
        logic [24:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(res), 32'(e[24:9]));
                    check("iter", 32'(iter), 32'(e[8:1]));
                    check("error", 32'(err), 32'(e[0]));
                end
            end
            prev = res_valid;
        end
    end

    initial begin
        logic        prev;
        logic [24:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (c4_valid && !prev) begin
                if (exp4_q.size() == 0) begin
                    check("unexpected_valid_c4", 32'(c4_valid), 32'd0);
                end else begin
                    e = exp4_q.pop_front();
                    check("result_c4", 32'(c4_res), 32'(e[24:9]));
                    check("iter_c4", 32'(c4_iter), 32'(e[8:1]));
                    check("error_c4", 32'(c4_err), 32'(e[0]));
                end
            end
            prev = c4_valid;
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(posedge clk);
        #1;
        nreset     = 1'b0;
        gcd_enable = 1'b0;
        force_bad  = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] r, input int it, input logic e);
        a_in = a;
        b_in = b;
        exp_q.push_back(pack(r, it, e, 255));
        exp4_q.push_back(pack(r, it, e, 15));
        gcd_enable = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (res_valid) done = 1'b1;
        end
        check({name, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    // Directed vectors: a, b, gcd, subtraction steps
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           it;
    } vec_t;

    vec_t vecs[5] = '{
        '{16'd7,    16'd7, 16'd7,  0},
        '{16'd13,   16'd5, 16'd1,  5},
        '{16'd35,   16'd0, 16'd35, 0},
        '{16'd0,    16'd0, 16'd0,  0},
        '{16'd1000, 16'd1, 16'd1,  999}
    };

    initial begin
        nreset     = 1'b0;
        gcd_enable = 1'b0;
        force_bad  = 1'b0;
        a_in       = '0;
        b_in       = '0;

        // Reset state, observed before any clock edge
        #3;
        check("rst_result", 32'(res), 32'd0);
        check("rst_iter", 32'(iter), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_error", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // 12, 18 -> 6 in 2 steps; finish ignores later operand changes
        start_op(16'd12, 16'd18, 16'd6, 2, 1'b0);
        wait_valid("gcd_12_18");
        a_in = 16'd40;
        b_in = 16'd30;
        repeat (3) @(posedge clk);
        #1;
        check("finish_hold_result", 32'(res), 32'd6);
        check("finish_hold_iter", 32'(iter), 32'd2);
        check("finish_hold_valid", 32'(res_valid), 32'd1);
        check("finish_cz", 32'(cz), 32'd0);
        check("finish_ce", 32'(ce), 32'd0);

        // 0, 7 -> straight to finish with result 7
        do_reset();
        a_in = 16'd0;
        b_in = 16'd7;
        #1;
        check("zero_cz_init", 32'(cz), 32'd1);
        check("zero_ce_init", 32'(ce), 32'd0);
        start_op(16'd0, 16'd7, 16'd7, 0, 1'b0);
        @(posedge clk);
        #1;
        check("zero_direct_finish", 32'(flag_finish), 32'd1);
        check("zero_result_loaded", 32'(res), 32'd7);
        wait_valid("gcd_0_7");

        // Nonzero operands in init request compute
        do_reset();
        a_in = 16'd9;
        b_in = 16'd4;
        #1;
        check("init_ce", 32'(ce), 32'd1);
        check("init_cz", 32'(cz), 32'd0);

        // 17, 1: 16 steps, saturates the 4-bit counter at 15
        do_reset();
        start_op(16'd17, 16'd1, 16'd1, 16, 1'b0);
        wait_valid("gcd_17_1");

        // 48, 36 with enable dropped for 5 cycles after the first step
        do_reset();
        start_op(16'd48, 16'd36, 16'd12, 3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        gcd_enable = 1'b0;
        a_in       = 16'd0;
        b_in       = 16'd0;
        repeat (5) @(posedge clk);
        #1;
        check("freeze_iter", 32'(iter), 32'd1);
        check("freeze_valid", 32'(res_valid), 32'd0);
        check("freeze_result", 32'(res), 32'd0);
        check("freeze_cz", 32'(cz), 32'd0);
        gcd_enable = 1'b1;
        wait_valid("gcd_48_36");

        // Reset pulse mid-compute of 100, 75, then rerun with 9, 6
        do_reset();
        a_in       = 16'd100;
        b_in       = 16'd75;
        gcd_enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_running_iter", 32'(iter), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("abort_result", 32'(res), 32'd0);
        check("abort_iter", 32'(iter), 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_error", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        start_op(16'd9, 16'd6, 16'd3, 2, 1'b0);
        wait_valid("gcd_9_6");

        // Two flags high for one edge: sticky error through a full run
        do_reset();
        a_in       = 16'd5;
        b_in       = 16'd3;
        gcd_enable = 1'b1;
        force_bad  = 1'b1;
        #1;
        check("bad_cz", 32'(cz), 32'd0);
        check("bad_ce", 32'(ce), 32'd0);
        @(posedge clk);
        #1;
        force_bad = 1'b0;
        check("bad_error_set", 32'(err), 32'd1);
        check("bad_iter_hold", 32'(iter), 32'd0);
        start_op(16'd5, 16'd3, 16'd1, 3, 1'b1);
        wait_valid("gcd_5_3_err");
        repeat (3) @(posedge clk);
        #1;
        check("error_sticky", 32'(err), 32'd1);
        do_reset();
        check("error_cleared", 32'(err), 32'd0);

        // Table of further vectors
        for (int i = 0; i < 5; i++) begin
            do_reset();
            start_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].it, 1'b0);
            wait_valid("table");
        end

        // Anything left in the queues never came out
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL leftover: got %0d unconsumed expectations, expected 0", exp_q.size() + exp4_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gcd_datapath.md
GCD_DATAPATH -- requirements
Module: gcd_datapath

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the iteration counter width in bits.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port nreset_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port gcd_enable_i, input, 1 bit: global step enable, shared with the control FSM.
REQ-006 The module SHALL have ports a_i and b_i, input, WIDTH bits each: operands, sampled in init.
REQ-007 The module SHALL have ports flag_init_i, flag_compute_i and flag_finish_i, input, 1 bit each: state flags from the control FSM.
REQ-008 The module SHALL have port compute_enable_o, output, 1 bit, combinational: request to the FSM to go from init to compute.
REQ-009 The module SHALL have port compare_zero_o, output, 1 bit, combinational: termination condition to the FSM.
REQ-010 The module SHALL have port result_o, output, WIDTH bits, registered: the GCD result.
REQ-011 The module SHALL have port result_valid_o, output, 1 bit, registered: result_o holds a final value.
REQ-012 The module SHALL have port iter_count_o, output, CNT_W bits, registered: number of subtraction steps performed.
REQ-013 The module SHALL have port flag_error_o, output, 1 bit, registered, sticky: a protocol violation was seen on the flag inputs.

Function
REQ-014 In init (flag_init_i=1), compute_enable_o SHALL equal (a_i!=0)&&(b_i!=0), and compare_zero_o SHALL equal (a_i==0)||(b_i==0).
REQ-015 In init with gcd_enable_i=1, each edge SHALL load a_reg<=a_i, b_reg<=b_i, iter_count_o<=0 and result_valid_o<=0.
REQ-016 In init with gcd_enable_i=1 and compare_zero_o=1, the edge SHALL also load result_o<=a_i|b_i, so gcd(0,x)=x and gcd(0,0)=0.
REQ-017 In compute (flag_compute_i=1), compare_zero_o SHALL equal (a_reg==b_reg), and compute_enable_o SHALL be 0.
REQ-018 In compute with gcd_enable_i=1 and a_reg>b_reg, the edge SHALL set a_reg<=a_reg-b_reg and increment iter_count_o.
REQ-019 In compute with gcd_enable_i=1 and b_reg>a_reg, the edge SHALL set b_reg<=b_reg-a_reg and increment iter_count_o.
REQ-020 In compute with gcd_enable_i=1 and a_reg==b_reg, the edge SHALL load result_o<=a_reg and leave a_reg, b_reg and the counter unchanged.
REQ-021 Subtraction SHALL be unsigned WIDTH-bit, performed only larger-minus-smaller, so it never wraps.
REQ-022 iter_count_o SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-023 In finish (flag_finish_i=1), result_valid_o SHALL be 1 from the first edge, and all datapath registers SHALL hold their values.
REQ-024 In finish, compare_zero_o and compute_enable_o SHALL both be 0.
REQ-025 With gcd_enable_i=0, all registers except flag_error_o SHALL hold their values; the combinational outputs SHALL still follow REQ-014/REQ-017.
REQ-026 If not exactly one flag input is high on an edge, flag_error_o SHALL be set; combinational outputs SHALL be 0 and datapath registers SHALL hold on that edge.
REQ-027 Finish SHALL be exited only by reset; later changes of a_i and b_i SHALL have no effect.

Reset
REQ-028 While nreset_i=0, a_reg, b_reg, result_o, iter_count_o, result_valid_o and flag_error_o SHALL be 0, independent of clk_i.
REQ-029 Reset asserted mid-compute SHALL abort immediately, and the next operation SHALL start from init with no residual state.

Structure
REQ-030 A shared package gcd_pkg SHALL hold the WIDTH and CNT_W defaults and the FSM state enum (S_INIT, S_COMPUTE, S_FINISH) used by both ends.
REQ-031 One sub-module, gcd_sub_step, SHALL hold the compare/subtract step (inputs a, b; outputs a_gt_b, eq, difference); all control SHALL stay in gcd_datapath.

Verification
REQ-032 Scenario a=12, b=18 with the FSM connected: the bench SHALL check result_o=6, iter_count_o=2, result_valid_o=1 and flag_error_o=0.
REQ-033 Scenario a=0, b=7: the bench SHALL check compare_zero_o=1 in init, a direct move to finish, result_o=7 and iter_count_o=0; for a=0, b=0 it SHALL check result_o=0.
REQ-034 Scenario CNT_W=4, a=17, b=1: the bench SHALL check result_o=1 and iter_count_o saturated at 15.
REQ-035 Scenario a=48, b=36 with gcd_enable_i low for 5 cycles mid-compute: the bench SHALL check the registers are frozen, then resume to result_o=12, iter_count_o=3.
REQ-036 Scenario nreset_i pulsed low mid-compute of (100, 75): the bench SHALL check all outputs clear asynchronously, then a rerun with (9, 6) gives result_o=3.
REQ-037 Scenario flag_init_i and flag_compute_i both forced to 1: the bench SHALL check flag_error_o=1 and that it stays 1 until reset.
